// File: rtl/gold_sequence_generator.sv
// Gold code generator: two Fibonacci LFSRs of a preferred pair XORed per chip,
// with run-time seeds, valid/ready output, period sync marker and chip index.
module gold_sequence_generator #(
    parameter int unsigned     M      = 5,
    parameter logic [M-1:0]    POLY_A = 5'b00101,
    parameter logic [M-1:0]    POLY_B = 5'b11101
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [M-1:0] seed_a,
    input  logic [M-1:0] seed_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         chip,
    output logic         sync,
    output logic [M-1:0] chip_index,
    output logic         seed_fault
);

    generate
        if (M < 3 || M > 10) begin : g_bad_m
            $error("gold_sequence_generator: M must be in 3..10");
        end
    endgenerate

    localparam logic [M-1:0] LAST_INDEX = {M{1'b1}} - 1'b1 + 1'b1 - 1'b1;
    localparam logic [M-1:0] ALL_ONES   = {M{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] a_next;
    logic [M-1:0] b_next;
    logic [M-1:0] load_a;
    logic [M-1:0] load_b;
    logic [M-1:0] index_next;
    logic         zero_seed;
    logic         handshake;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; load wins from any state
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = enable ? RUN : HOLD;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                RUN:     state_next = enable ? RUN : HOLD;
                HOLD:    state_next = enable ? RUN : HOLD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        out_valid = 1'b0;
        unique case (state)
            IDLE:    out_valid = 1'b0;
            RUN:     out_valid = 1'b1;
            HOLD:    out_valid = 1'b0;
            default: out_valid = 1'b0;
        endcase
    end

    assign handshake = out_valid && out_ready;

    // A zero seed would lock the LFSR, so it is replaced by all ones
    always_comb begin
        load_a    = (seed_a == '0) ? ALL_ONES : seed_a;
        load_b    = (seed_b == '0) ? ALL_ONES : seed_b;
        zero_seed = (seed_a == '0) || (seed_b == '0);
    end

    always_comb begin
        a_next     = {^(a & POLY_A), a[M-1:1]};
        b_next     = {^(b & POLY_B), b[M-1:1]};
        index_next = (chip_index == LAST_INDEX) ? '0 : chip_index + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a          <= ALL_ONES;
            b          <= ALL_ONES;
            chip_index <= '0;
            seed_fault <= 1'b0;
        end else if (load) begin
            a          <= load_a;
            b          <= load_b;
            chip_index <= '0;
            seed_fault <= seed_fault | zero_seed;
        end else if (handshake) begin
            a          <= a_next;
            b          <= b_next;
            chip_index <= index_next;
        end
    end

    assign chip = a[0] ^ b[0];
    assign sync = out_valid && (chip_index == '0);

endmodule

// File: tb/tb_gold_sequence_generator.sv
// Randomized bench for gold_sequence_generator against a recurrence-based
// model of the two m-sequences and a handshake-counting index model.
module tb_gold_sequence_generator;

    localparam int M = 5;
    localparam int N = 31;
    localparam logic [M-1:0] POLY_A = 5'b00101;
    localparam logic [M-1:0] POLY_B = 5'b11101;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         load = 1'b0;
    logic [M-1:0] seed_a = '0;
    logic [M-1:0] seed_b = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic         chip;
    logic         sync;
    logic [M-1:0] chip_index;
    logic         seed_fault;

    int errors = 0;
    int checks = 0;

    bit           m_valid = 0;
    bit           m_active = 0;
    bit           m_fault = 0;
    int           m_idx = 0;
    logic [N-1:0] m_sa = '0;
    logic [N-1:0] m_sb = '0;

    gold_sequence_generator #(
        .M(M),
        .POLY_A(POLY_A),
        .POLY_B(POLY_B)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .load(load),
        .seed_a(seed_a),
        .seed_b(seed_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .chip(chip),
        .sync(sync),
        .chip_index(chip_index),
        .seed_fault(seed_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output bit s[n]; s[n+M] is the XOR of the tapped s[n+i]
    function automatic logic [N-1:0] mseq(input logic [M-1:0] seed,
                                          input logic [M-1:0] poly);
        logic [N-1:0] s;
        logic         fb;
        s = '0;
        for (int i = 0; i < M; i++) s[i] = seed[i];
        for (int n = M; n < N; n++) begin
            fb = 1'b0;
            for (int i = 0; i < M; i++)
                if (poly[i]) fb = fb ^ s[n-M+i];
            s[n] = fb;
        end
        return s;
    endfunction

    task automatic tick();
        bit           hs;
        logic [M-1:0] sa;
        logic [M-1:0] sb;
        @(posedge clock);
        hs = m_valid && out_ready;
        if (!reset) begin
            m_valid  = 0;
            m_active = 0;
            m_idx    = 0;
            m_fault  = 0;
        end else if (load) begin
            sa = (seed_a == '0) ? 5'b11111 : seed_a;
            sb = (seed_b == '0) ? 5'b11111 : seed_b;
            if (seed_a == '0 || seed_b == '0) m_fault = 1;
            m_sa     = mseq(sa, POLY_A);
            m_sb     = mseq(sb, POLY_B);
            m_idx    = 0;
            m_active = 1;
            m_valid  = enable;
        end else begin
            if (hs) m_idx = (m_idx + 1) % N;
            if (m_active) m_valid = enable;
        end
        #1;
        check("valid", out_valid, m_valid);
        check("fault", seed_fault, m_fault);
        if (m_valid) begin
            check("chip", chip, m_sa[m_idx] ^ m_sb[m_idx]);
            check("index", chip_index, m_idx);
            check("sync", sync, m_idx == 0);
        end else begin
            check("sync_off", sync, 0);
        end
    endtask

    initial begin
        logic [9:0] first_ten;
        int         hs_count;
        int         low_count;
        int         guard;

        first_ten = 10'b1101000000;

        reset = 1'b0;
        tick();
        tick();
        check("rst_chip", chip, 0);
        check("rst_index", chip_index, 0);
        reset = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        tick();
        check("idle_no_valid", out_valid, 0);

        seed_a = 5'b00001;
        seed_b = 5'b00001;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("first_ten", chip, first_ten[k]);
            tick();
        end

        // Continuous run, sync must appear every 31 handshakes
        hs_count = 10;
        for (int k = 0; k < 70; k++) begin
            if (sync) check("sync_pos", hs_count % N, 0);
            hs_count++;
            tick();
        end

        // Random back-pressure
        for (int k = 0; k < 100; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;

        // Enable drop at index 7
        guard = 0;
        while (m_idx != 7 && guard < 64) begin
            tick();
            guard++;
        end
        check("reach_idx7", chip_index, 7);
        enable = 1'b0;
        low_count = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!out_valid) low_count++;
        end
        check("hold_cycles", low_count, 5);
        enable = 1'b1;
        tick();
        check("resume_idx", chip_index, 8);
        check("resume_valid", out_valid, 1);

        // Load with zero seed_a while chips are being accepted
        guard = 0;
        while (m_idx != 12 && guard < 64) begin
            tick();
            guard++;
        end
        check("reach_idx12", chip_index, 12);
        seed_a = 5'b00000;
        seed_b = 5'(($urandom % 31) + 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        check("reload_idx", chip_index, 0);
        check("reload_fault", seed_fault, 1);
        check("reload_sync", sync, 1);
        for (int k = 0; k < 40; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Random seeds with load while paused, then random enable/ready
        seed_a = 5'(($urandom % 31) + 1);
        seed_b = 5'(($urandom % 31) + 1);
        enable = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 80; k++) begin
            enable = ($urandom_range(0, 7) != 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset mid-run
        enable = 1'b1;
        out_ready = 1'b1;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sync", sync, 0);
        check("mid_rst_fault", seed_fault, 0);
        for (int k = 0; k < 5; k++) tick();
        check("idle_after_rst", out_valid, 0);

        seed_a = 5'b10011;
        seed_b = 5'b01110;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 35; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gold_sequence_generator.md
Name: gold_sequence_generator

Overview:
- Parametrised Gold code generator: two M-stage Fibonacci LFSRs (preferred pair) XORed to produce one chip per accepted transfer.
- Seeds are loadable at run time, so any Gold code of the family (any relative phase) is selectable.
- Output uses a valid/ready stream with a per-period sync marker and chip index.
- Sits between the spreading-code config registers and the spreader/correlator datapath.

Parameters:
- M, 5, LFSR length; legal range 3..10. Period N = 2^M - 1.
- POLY_A, 5'b00101, M-bit tap mask for LFSR A; bit i is the x^i coefficient of the characteristic polynomial (x^M implicit). The default is x^5+x^2+1.
- POLY_B, 5'b11101, tap mask for LFSR B. The default is x^5+x^4+x^3+x^2+1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low
- enable  in  1  run gate; low pauses generation
- load  in  1  one-cycle strobe; captures seeds and restarts the period
- seed_a  in  M  initial state for LFSR A
- seed_b  in  M  initial state for LFSR B
- out_valid  out  1  chip is valid
- out_ready  in  1  downstream accepts chip
- chip  out  1  Gold chip = a[0] ^ b[0]
- sync  out  1  high while the presented chip is index 0 of the period
- chip_index  out  M  index of the presented chip, 0..N-1
- seed_fault  out  1  sticky flag: a zero seed was substituted

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE; a=b={M{1'b1}}; chip_index=0.
  - out_valid=0, sync=0, seed_fault=0, chip=0.
  - Reset has priority over every other input. Reset mid-stream drops the pending chip; no handshake completes on that edge.
- States: IDLE, RUN, HOLD.
  - IDLE: out_valid=0; leaves only on load.
  - RUN: out_valid=1.
  - HOLD: out_valid=0; registers frozen.
- Load:
  - load=1 at an edge in any state: a<=seed_a, b<=seed_b, chip_index<=0.
  - Next state: RUN if enable=1, else HOLD.
  - A zero seed is replaced by {M{1'b1}} and sets seed_fault, which stays set until reset.
  - load overrides a simultaneous handshake; the chip presented on that edge is discarded.
- Enable:
  - RUN with enable=0 -> HOLD.
  - HOLD with enable=1 -> RUN.
  - This transition is registered, so out_valid follows enable with 1-cycle latency.
  - A handshake on the same edge that enable falls still completes.
- Advance: on out_valid&&out_ready in RUN, with no load:
  - a <= {^(a & POLY_A), a[M-1:1]}; likewise b with POLY_B.
  - chip_index <= (chip_index==N-1) ? 0 : chip_index+1. The wrap is a true modulo-N wrap, not a power-of-two wrap.
- Stall: out_valid=1 with out_ready=0 holds chip, sync and chip_index stable; no state advances.
- Output timing:
  - chip and sync are combinational from registered state: chip=a[0]^b[0], sync=out_valid && chip_index==0.
  - The first chip after load is presented on the cycle after the load edge; latency is 1 cycle.
- Full throughput: one chip per cycle with out_ready held high.
- M outside 3..10: elaboration error.

Test Plan:
- Reset then load (seed_a=5'b00001, seed_b=5'b00001, enable=1, out_ready=1) -> one cycle later out_valid=1, sync=1, chip_index=0. The first 10 chips are 0,0,0,0,0,0,1,0,1,1.
- Continuous run for 70 cycles -> sync asserted on handshakes 0, 31 and 62. chip_index wraps 30->0. The chip sequence repeats with period 31 and matches the bench LFSR model.
- Toggle out_ready 1/0 randomly over 100 cycles -> chip, sync and chip_index stable while out_ready=0. The accepted chip stream is identical to the no-stall run.
- Drop enable at chip_index=7 for 5 cycles, then raise it:
  - the handshake on the falling edge completes;
  - out_valid=0 for 5 cycles;
  - the stream resumes at chip_index=8 with no skipped or duplicated chip.
- load with seed_a=0 at chip_index=12 while the output is being accepted -> the pending chip is discarded and seed_fault=1. Output restarts at index 0 with a=5'b11111, b=seed_b.
- Assert reset for 1 cycle mid-run -> next cycle out_valid=0, sync=0, state IDLE. No output until the next load.
